// File: rtl/psum_collector_pkg.sv
// Shared types and constants for the top-row psum collector.
// Packet layout, state encoding and the psum-to-byte conversion live here.
package psum_collector_pkg;

    localparam int PSUM_DATA_SIZE = 12;
    localparam int IFDATA_SIZE    = 8;
    localparam int NUM_FILTER     = 4;
    localparam int WORD_CNT_W     = 6;
    localparam int WORD_W         = NUM_FILTER * IFDATA_SIZE;

    typedef struct packed {
        logic                             valid;
        logic signed [PSUM_DATA_SIZE-1:0] psum;
        logic [1:0]                       filter_idx;
    } PSUM_PACKET;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_FLUSH
    } collector_state_e;

    // ReLU, drop the fraction bits, clamp into one output byte.
    function automatic logic [IFDATA_SIZE-1:0] relu_shift_sat(
        input logic signed [PSUM_DATA_SIZE-1:0] p,
        input int                               shift
    );
        logic signed [PSUM_DATA_SIZE-1:0] s;
        s = p >>> shift;
        if (p < 0)
            return '0;
        if (int'(s) > (1 << IFDATA_SIZE) - 1)
            return '1;
        return s[IFDATA_SIZE-1:0];
    endfunction

endpackage

// File: rtl/psum_collector_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts just after the last
// accepted grant; the pointer only moves when the grant is actually taken.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         accept,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;

    // Walk from the farthest candidate back to ptr so the nearest request wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int            idx;
            logic [PW-1:0] idx_b;
            idx = int'(ptr) + k;
            if (idx >= N)
                idx = idx - N;
            idx_b = PW'(idx);
            if (req[idx_b]) begin
                grant        = '0;
                grant[idx_b] = 1'b1;
                gidx         = idx_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (accept)
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    end

endmodule

// File: rtl/psum_collector.sv
// Collects top-row psum packets from the PE columns, converts them to bytes
// and packs four bytes per filter into 32-bit writes with per-filter addresses.
module psum_collector
    import psum_collector_pkg::*;
#(
    parameter int NUM_COL   = 4,
    parameter int OUT_SHIFT = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      flush,
    input  PSUM_PACKET [NUM_COL-1:0]  psum_in,
    output logic [NUM_COL-1:0]        psum_ack,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [WORD_W-1:0]         wr_data,
    output logic [7:0]                wr_addr,
    output logic                      busy,
    output logic                      done
);

    collector_state_e state;

    logic [WORD_W-1:0]     lane_data [NUM_FILTER];
    logic [1:0]            lane_cnt  [NUM_FILTER];
    logic [WORD_CNT_W-1:0] word_cnt  [NUM_FILTER];

    logic [NUM_COL-1:0]               req;
    logic [NUM_COL-1:0]               grant;
    logic signed [PSUM_DATA_SIZE-1:0] sel_psum;
    logic [1:0]                       sel_fi;
    logic [IFDATA_SIZE-1:0]           sel_byte;
    logic                             sel_completes;
    logic                             out_free;
    logic                             drain;
    logic                             blocked;
    logic                             take;
    logic                             flush_any;
    logic [1:0]                       flush_lane;

    // start wins over collection: nothing is taken while counters are cleared.
    always_comb begin
        req = '0;
        for (int c = 0; c < NUM_COL; c++)
            req[c] = psum_in[c].valid;
        if (state != ST_COLLECT || start)
            req = '0;
    end

    rr_arbiter #(.N(NUM_COL)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .clr    (start),
        .accept (take),
        .req    (req),
        .grant  (grant)
    );

    always_comb begin
        sel_psum = '0;
        sel_fi   = '0;
        for (int c = 0; c < NUM_COL; c++) begin
            if (grant[c]) begin
                sel_psum = psum_in[c].psum;
                sel_fi   = psum_in[c].filter_idx;
            end
        end
    end

    assign sel_byte      = relu_shift_sat(sel_psum, OUT_SHIFT);
    assign drain         = wr_valid && wr_ready;
    assign out_free      = !wr_valid || wr_ready;
    assign sel_completes = (lane_cnt[sel_fi] == 2'd3);
    // A word-completing packet must wait until the output register can take it.
    assign blocked       = sel_completes && !out_free;
    assign take          = (|grant) && !blocked;
    assign psum_ack      = take ? grant : '0;
    assign busy          = (state != ST_IDLE);

    // Lowest-numbered non-empty lane drains first.
    always_comb begin
        flush_any  = 1'b0;
        flush_lane = '0;
        for (int f = NUM_FILTER - 1; f >= 0; f--) begin
            if (lane_cnt[f] != 2'd0) begin
                flush_any  = 1'b1;
                flush_lane = 2'(f);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            wr_valid <= 1'b0;
            wr_data  <= '0;
            wr_addr  <= '0;
            done     <= 1'b0;
            for (int f = 0; f < NUM_FILTER; f++) begin
                lane_data[f] <= '0;
                lane_cnt[f]  <= '0;
                word_cnt[f]  <= '0;
            end
        end else begin
            done <= 1'b0;
            if (drain)
                wr_valid <= 1'b0;

            if (start) begin
                state <= ST_COLLECT;
                for (int f = 0; f < NUM_FILTER; f++) begin
                    lane_data[f] <= '0;
                    lane_cnt[f]  <= '0;
                    word_cnt[f]  <= '0;
                end
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_COLLECT: begin
                        if (take) begin
                            if (sel_completes) begin
                                wr_valid          <= 1'b1;
                                wr_data           <= {sel_byte, lane_data[sel_fi][3*IFDATA_SIZE-1:0]};
                                wr_addr           <= {sel_fi, word_cnt[sel_fi]};
                                word_cnt[sel_fi]  <= word_cnt[sel_fi] + 1'b1;
                                lane_data[sel_fi] <= '0;
                                lane_cnt[sel_fi]  <= '0;
                            end else begin
                                lane_data[sel_fi][{lane_cnt[sel_fi], 3'b000} +: IFDATA_SIZE] <= sel_byte;
                                lane_cnt[sel_fi] <= lane_cnt[sel_fi] + 1'b1;
                            end
                        end
                        if (flush)
                            state <= ST_FLUSH;
                    end
                    ST_FLUSH: begin
                        if (flush_any && out_free) begin
                            // Lanes are zeroed on clear, so unused bytes go out as zero.
                            wr_valid              <= 1'b1;
                            wr_data               <= lane_data[flush_lane];
                            wr_addr               <= {flush_lane, word_cnt[flush_lane]};
                            word_cnt[flush_lane]  <= word_cnt[flush_lane] + 1'b1;
                            lane_data[flush_lane] <= '0;
                            lane_cnt[flush_lane]  <= '0;
                        end else if (!flush_any && !wr_valid) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
